// File: rtl/trax_pkg.sv
// trax_pkg: ASCII constants, tile symbol codes and parser states shared by the Trax move parser
package trax_pkg;
  localparam logic [7:0] CH_AT = 8'h40;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_Z  = 8'h5A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_SL = 8'h2F;
  localparam logic [7:0] CH_PL = 8'h2B;
  localparam logic [7:0] CH_BS = 8'h5C;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [1:0] SYM_BS = 2'd1;
  localparam logic [1:0] SYM_PL = 2'd2;
  localparam logic [1:0] SYM_SL = 2'd3;
  typedef enum logic [2:0] {ST_IDLE, ST_COL2, ST_ROW1, ST_ROW2, ST_TYPE, ST_DONE, ST_ERR} state_t;
endpackage

// File: rtl/trax_char_class.sv
// trax_char_class: classifies an ASCII byte into Trax notation classes and its numeric value
module trax_char_class
  import trax_pkg::*;
(
  input  logic [7:0] c,
  output logic       is_at,
  output logic       is_letter,
  output logic       is_digit,
  output logic       is_type,
  output logic       is_ws,
  output logic [4:0] val
);
  logic [1:0] sym;
  assign is_at     = c == CH_AT;
  assign is_letter = c >= CH_A && c <= CH_Z;
  assign is_digit  = c >= CH_0 && c <= CH_9;
  assign sym       = c == CH_BS ? SYM_BS : c == CH_PL ? SYM_PL : c == CH_SL ? SYM_SL : 2'd0;
  assign is_type   = sym != 2'd0;
  assign is_ws     = c == CH_SP || c == CH_CR || c == CH_LF;
  // 'A'..'Z' low five bits are already 1..26, '0'..'9' low nibble is the digit
  assign val = is_letter ? c[4:0] : is_digit ? {1'b0, c[3:0]} : {3'd0, sym};
endmodule

// File: rtl/trax_move_parser.sv
// trax_move_parser: parses a serial Trax move ("B3/", "AA12\") into absolute coordinates and symbol
module trax_move_parser
  import trax_pkg::*;
#(
  parameter int X_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [X_W:0] off_x,
  input  logic [X_W:0] off_y,
  output logic [X_W:0] out_x,
  output logic [X_W:0] out_y,
  output logic [1:0]   out_sym,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);
  localparam int W = X_W + 1;
  state_t       state;
  logic [X_W:0] col, row;
  logic         is_at, is_letter, is_digit, is_type, is_ws, acc, bad;
  logic [4:0]   val;
  trax_char_class u_cls (
    .c(in_data), .is_at(is_at), .is_letter(is_letter), .is_digit(is_digit),
    .is_type(is_type), .is_ws(is_ws), .val(val)
  );
  assign in_ready = state != ST_DONE;
  assign acc      = in_valid && in_ready;
  always_comb begin
    bad = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: bad = !(is_at || is_letter || is_ws);
      ST_COL2:         bad = !(is_letter || is_digit);
      ST_ROW1:         bad = !is_digit;
      ST_ROW2:         bad = !(is_type || (is_digit && row != '0));
      ST_TYPE:         bad = !is_type;
      default:         bad = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_sym   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (acc && bad) begin
        state <= ST_ERR;
        err   <= 1'b1;
        col   <= '0;
        row   <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_ERR: begin
            state <= ST_IDLE;
            if (acc && is_at) begin
              col   <= '0;
              state <= ST_ROW1;
            end else if (acc && is_letter) begin
              col   <= W'(val);
              state <= ST_COL2;
            end
          end
          ST_COL2: if (acc) begin
            if (is_letter) begin
              col   <= col * W'(26) + W'(val);
              state <= ST_ROW1;
            end else begin
              row   <= W'(val);
              state <= ST_ROW2;
            end
          end
          ST_ROW1: if (acc) begin
            row   <= W'(val);
            state <= ST_ROW2;
          end
          ST_ROW2, ST_TYPE: if (acc) begin
            if (is_digit) begin
              row   <= row * W'(10) + W'(val);
              state <= ST_TYPE;
            end else begin
              out_x     <= col + off_x;
              out_y     <= row + off_y;
              out_sym   <= val[1:0];
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
          ST_DONE: if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
